s2_lane_serializer: RTL and testbench

//  Parametrised successor of the s2 word-to-byte stage. Latches a DW-bit word and

---
 rtl/s2_lane_serializer_if.sv | 29 ++
 rtl/s2_lane_serializer.sv | 92 +++++++++
 tb/tb_s2_lane_serializer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/s2_lane_serializer_if.sv
// Word-in / lane-out bus of the s2 lane serializer.
// The master side is the word producer plus the lane consumer; the slave side is the serializer.
interface s2_lane_serializer_if #(
    parameter int DW = 16,
    parameter int LW = 8
);
    localparam int SELW = $clog2(DW / LW);

    logic            pl;
    logic            plr;
    logic            mode;
    logic [SELW-1:0] sel;
    logic [DW-1:0]   di;
    logic [LW-1:0]   dout;
    logic            do_valid;
    logic            do_ready;
    logic            busy;
    logic            done;

    modport master (
        output pl, plr, mode, sel, di, do_ready,
        input  dout, do_valid, busy, done
    );

    modport slave (
        input  pl, plr, mode, sel, di, do_ready,
        output dout, do_valid, busy, done
    );
endinterface

// File: rtl/s2_lane_serializer.sv
// Latches a DW-bit word and hands it out LW bits at a time, either one
// selected lane per plr strobe or as a valid/ready stream of every lane.
module s2_lane_serializer #(
    parameter int DW        = 16,
    parameter int LW        = 8,
    parameter int MSB_FIRST = 0
) (
    input logic                  clk,
    input logic                  reset,
    s2_lane_serializer_if.slave  bus
);
    localparam int LANES = DW / LW;
    localparam int SELW  = $clog2(LANES);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state;
    logic [DW-1:0]   hold;
    logic [SELW-1:0] cnt;
    logic [LW-1:0]   dout_q;
    logic            valid_q;
    logic            busy_q;
    logic            done_q;

    function automatic logic [LW-1:0] lane_of(input logic [DW-1:0] w, input int k);
        return w[k*LW +: LW];
    endfunction

    // Stream position p maps to physical lane p, or the mirror of it when MSB_FIRST is set.
    function automatic int lane_idx(input int p);
        return (MSB_FIRST != 0) ? (LANES - 1 - p) : p;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            hold    <= '0;
            cnt     <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (bus.pl && bus.mode) begin
                        hold    <= bus.di;
                        cnt     <= '0;
                        dout_q  <= lane_of(bus.di, lane_idx(0));
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= STREAM;
                    end else begin
                        if (bus.pl) begin
                            hold <= bus.di;
                        end
                        // A same-cycle pl feeds the new word straight through to the lane mux.
                        if (bus.plr) begin
                            if (int'(bus.sel) >= LANES) begin
                                dout_q <= '0;
                            end else begin
                                dout_q <= lane_of(bus.pl ? bus.di : hold, int'(bus.sel));
                            end
                            valid_q <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (valid_q && bus.do_ready) begin
                        if (int'(cnt) == LANES - 1) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            cnt    <= cnt + SELW'(1);
                            dout_q <= lane_of(hold, lane_idx(int'(cnt) + 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.dout     = dout_q;
    assign bus.do_valid = valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_s2_lane_serializer.sv
// Self-checking bench for s2_lane_serializer: a 16/8 LSB-first instance and
// a 32/8 MSB-first instance, with a lane scoreboard per instance.
module tb_s2_lane_serializer;
    logic clk;
    logic reset;

    s2_lane_serializer_if #(.DW(16), .LW(8)) a16 ();
    s2_lane_serializer_if #(.DW(32), .LW(8)) a32 ();

    s2_lane_serializer #(.DW(16), .LW(8), .MSB_FIRST(0)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (a16.slave)
    );

    s2_lane_serializer #(.DW(32), .LW(8), .MSB_FIRST(1)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (a32.slave)
    );

    typedef struct packed {
        logic        pl;
        logic        plr;
        logic        sel;
        logic [15:0] di;
        logic [7:0]  expDout;
    } manVec_t;

    manVec_t    manTab [6];
    logic [7:0] q16 [$];
    logic [7:0] q32 [$];
    int         nCompared;
    int         nMismatched;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every lane handed over (manual pulse, or stream beat with ready) is popped and compared.
    always @(negedge clk) begin
        if (!reset && a16.do_valid && (a16.do_ready || !a16.busy)) begin
            if (q16.size() == 0) checkOutput("sb16_unexpected", {24'h0, a16.dout}, 32'hdead);
            else checkOutput("sb16_lane", {24'h0, a16.dout}, {24'h0, q16.pop_front()});
        end
        if (!reset && a32.do_valid && (a32.do_ready || !a32.busy)) begin
            if (q32.size() == 0) checkOutput("sb32_unexpected", {24'h0, a32.dout}, 32'hdead);
            else checkOutput("sb32_lane", {24'h0, a32.dout}, {24'h0, q32.pop_front()});
        end
    end

    task automatic applyStimulus(input manVec_t v);
        a16.pl   = v.pl;
        a16.plr  = v.plr;
        a16.sel  = v.sel;
        a16.di   = v.di;
        a16.mode = 1'b0;
        if (v.plr) q16.push_back(v.expDout);
        tick();
        a16.pl  = 1'b0;
        a16.plr = 1'b0;
        checkOutput("man_valid", {31'h0, a16.do_valid}, {31'h0, v.plr});
        if (v.plr) checkOutput("man_dout", {24'h0, a16.dout}, {24'h0, v.expDout});
        tick();
        checkOutput("man_valid_drop", {31'h0, a16.do_valid}, 32'h0);
    endtask

    task automatic checkIdle16(input string name);
        checkOutput({name, "_dout"}, {24'h0, a16.dout}, 32'h0);
        checkOutput({name, "_valid"}, {31'h0, a16.do_valid}, 32'h0);
        checkOutput({name, "_busy"}, {31'h0, a16.busy}, 32'h0);
        checkOutput({name, "_done"}, {31'h0, a16.done}, 32'h0);
    endtask

    initial begin
        logic [31:0] w;
        logic        sawDone;

        nCompared   = 0;
        nMismatched = 0;
        manTab[0] = '{pl: 1'b1, plr: 1'b1, sel: 1'b0, di: 16'h0ac5, expDout: 8'hc5};
        manTab[1] = '{pl: 1'b0, plr: 1'b1, sel: 1'b1, di: 16'h0000, expDout: 8'h0a};
        manTab[2] = '{pl: 1'b1, plr: 1'b0, sel: 1'b0, di: 16'h5a3c, expDout: 8'h00};
        manTab[3] = '{pl: 1'b0, plr: 1'b1, sel: 1'b0, di: 16'hffff, expDout: 8'h3c};
        manTab[4] = '{pl: 1'b1, plr: 1'b1, sel: 1'b1, di: 16'hbeef, expDout: 8'hbe};
        manTab[5] = '{pl: 1'b0, plr: 1'b1, sel: 1'b0, di: 16'h1234, expDout: 8'hef};

        // Reset held while every control input is asserted.
        reset = 1'b1;
        a16.pl = 1'b1; a16.plr = 1'b1; a16.mode = 1'b1; a16.sel = 1'b1;
        a16.di = 16'hffff; a16.do_ready = 1'b1;
        a32.pl = 1'b1; a32.plr = 1'b1; a32.mode = 1'b1; a32.sel = 2'd3;
        a32.di = 32'hffffffff; a32.do_ready = 1'b1;
        tick();
        tick();
        checkIdle16("reset16");
        checkOutput("reset32_valid", {31'h0, a32.do_valid}, 32'h0);
        checkOutput("reset32_busy", {31'h0, a32.busy}, 32'h0);
        checkOutput("reset32_dout", {24'h0, a32.dout}, 32'h0);
        a16.pl = 1'b0; a16.plr = 1'b0; a16.mode = 1'b0; a16.sel = 1'b0; a16.di = '0;
        a32.pl = 1'b0; a32.plr = 1'b0; a32.mode = 1'b0; a32.sel = '0; a32.di = '0;
        reset = 1'b0;
        tick();
        checkIdle16("post_reset16");

        $display("[TB] manual mode table");
        for (int i = 0; i < 6; i++) applyStimulus(manTab[i]);

        $display("[TB] auto stream, LSB first, plr ignored at launch");
        a16.pl = 1'b1; a16.mode = 1'b1; a16.di = 16'h0ac5; a16.plr = 1'b1; a16.sel = 1'b1;
        a16.do_ready = 1'b1;
        q16.push_back(8'hc5);
        q16.push_back(8'h0a);
        tick();
        a16.pl = 1'b0; a16.plr = 1'b0; a16.mode = 1'b0;
        checkOutput("auto_first", {24'h0, a16.dout}, 32'hc5);
        checkOutput("auto_busy", {31'h0, a16.busy}, 32'h1);
        tick();
        checkOutput("auto_second", {24'h0, a16.dout}, 32'h0a);
        checkOutput("auto_no_early_done", {31'h0, a16.done}, 32'h0);
        tick();
        checkOutput("auto_done", {31'h0, a16.done}, 32'h1);
        checkOutput("auto_busy_fall", {31'h0, a16.busy}, 32'h0);
        checkOutput("auto_valid_fall", {31'h0, a16.do_valid}, 32'h0);
        checkOutput("auto_dout_keep", {24'h0, a16.dout}, 32'h0a);
        tick();
        checkOutput("auto_done_pulse", {31'h0, a16.done}, 32'h0);

        $display("[TB] backpressure with ignored pl");
        a16.pl = 1'b1; a16.mode = 1'b1; a16.di = 16'h0ac5; a16.do_ready = 1'b0;
        q16.push_back(8'hc5);
        q16.push_back(8'h0a);
        tick();
        a16.di = 16'hffff;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_dout", {24'h0, a16.dout}, 32'hc5);
            checkOutput("stall_valid", {31'h0, a16.do_valid}, 32'h1);
        end
        a16.pl = 1'b0; a16.mode = 1'b0; a16.do_ready = 1'b1;
        tick();
        checkOutput("stall_resume", {24'h0, a16.dout}, 32'h0a);
        tick();
        checkOutput("stall_done", {31'h0, a16.done}, 32'h1);
        a16.plr = 1'b1; a16.sel = 1'b1;
        q16.push_back(8'h0a);
        tick();
        a16.plr = 1'b0;
        tick();

        $display("[TB] reset in the middle of a stream");
        a16.pl = 1'b1; a16.mode = 1'b1; a16.di = 16'h0ac5; a16.do_ready = 1'b1;
        q16.push_back(8'hc5);
        tick();
        a16.pl = 1'b0; a16.mode = 1'b0;
        @(negedge clk);
        #1;
        reset = 1'b1;
        tick();
        checkIdle16("midreset");
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("midreset_no_done", {31'h0, a16.done}, 32'h0);
        end
        a16.plr = 1'b1; a16.sel = 1'b1;
        q16.push_back(8'h00);
        tick();
        a16.plr = 1'b0;
        tick();
        checkOutput("q16_drained", q16.size(), 32'h0);

        $display("[TB] 32-bit MSB-first stream and pl in the done cycle");
        a32.pl = 1'b1; a32.mode = 1'b1; a32.di = 32'h11223344; a32.do_ready = 1'b1;
        q32.push_back(8'h11); q32.push_back(8'h22); q32.push_back(8'h33); q32.push_back(8'h44);
        tick();
        a32.pl = 1'b0; a32.mode = 1'b0;
        checkOutput("msb_first", {24'h0, a32.dout}, 32'h11);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("msb_done", {31'h0, a32.done}, 32'h1);
        checkOutput("msb_busy_fall", {31'h0, a32.busy}, 32'h0);
        a32.pl = 1'b1; a32.mode = 1'b1; a32.di = 32'ha1b2c3d4;
        q32.push_back(8'ha1); q32.push_back(8'hb2); q32.push_back(8'hc3); q32.push_back(8'hd4);
        tick();
        a32.pl = 1'b0; a32.mode = 1'b0;
        checkOutput("done_cycle_pl_busy", {31'h0, a32.busy}, 32'h1);
        checkOutput("done_cycle_pl_dout", {24'h0, a32.dout}, 32'ha1);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("second_done", {31'h0, a32.done}, 32'h1);
        a32.plr = 1'b1; a32.sel = 2'd2;
        q32.push_back(8'hb2);
        tick();
        a32.plr = 1'b0;
        tick();

        $display("[TB] random words with random backpressure");
        for (int n = 0; n < 4; n++) begin
            w = $urandom;
            for (int p = 0; p < 4; p++) q32.push_back(w[(3-p)*8 +: 8]);
            a32.pl = 1'b1; a32.mode = 1'b1; a32.di = w;
            tick();
            a32.pl = 1'b0; a32.mode = 1'b0;
            sawDone = 1'b0;
            for (int c = 0; c < 60 && !sawDone; c++) begin
                a32.do_ready = 1'($urandom_range(0, 1));
                tick();
                if (a32.done) sawDone = 1'b1;
            end
            checkOutput("rnd_done", {31'h0, sawDone}, 32'h1);
        end
        a32.do_ready = 1'b1;
        tick();
        checkOutput("q32_drained", q32.size(), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
